// File: rtl/fft_frame_sequencer.sv
// Frame-level controller for the FFT chain: gates N samples in, handshakes FFT completion and readout.
// Defining FRAME_TIMEOUT_EN adds a watchdog on the two wait states and the ERROR path.
module fft_frame_sequencer #(
  parameter int unsigned N         = 256,
  parameter int unsigned SIZE      = 8,
  parameter int unsigned FRAMES_W  = 8,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                continuous_i,
  input  logic                abort_i,
  input  logic                sample_valid_i,
  output logic                fft_in_valid_o,
  output logic                fft_in_last_o,
  input  logic                finish_fft_i,
  output logic                out_start_o,
  input  logic                out_done_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [FRAMES_W-1:0] frame_cnt_o,
  output logic                err_timeout_o
);

  typedef enum logic [6:0] {
    S_IDLE     = 7'b000_0001,
    S_COLLECT  = 7'b000_0010,
    S_WAIT_FFT = 7'b000_0100,
    S_KICK_OUT = 7'b000_1000,
    S_WAIT_OUT = 7'b001_0000,
    S_DONE     = 7'b010_0000,
    S_ERROR    = 7'b100_0000
  } state_t;

  localparam logic [SIZE-1:0] LAST_IDX = SIZE'(N - 1);

  state_t          state;
  logic [SIZE-1:0] cnt;

  // Sample path is a pure gate so the first sample can pass in the cycle after start is taken.
  assign busy_o         = (state != S_IDLE);
  assign fft_in_valid_o = sample_valid_i && (state == S_COLLECT);
  assign fft_in_last_o  = fft_in_valid_o && (cnt == LAST_IDX);

`ifdef FRAME_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd;
  logic                 wd_max;
  assign wd_max = &wd;
`else
  assign err_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      frame_cnt_o <= '0;
      out_start_o <= 1'b0;
      done_o      <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      wd            <= '0;
      err_timeout_o <= 1'b0;
`endif
    end else begin
      out_start_o <= 1'b0;
      done_o      <= 1'b0;
      if (abort_i) begin
        state <= S_IDLE;
        cnt   <= '0;
`ifdef FRAME_TIMEOUT_EN
        wd    <= '0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              state <= S_COLLECT;
              cnt   <= '0;
`ifdef FRAME_TIMEOUT_EN
              err_timeout_o <= 1'b0;
`endif
            end
          end
          S_COLLECT: begin
            if (sample_valid_i) begin
              if (cnt == LAST_IDX) begin
                state <= S_WAIT_FFT;
                cnt   <= '0;
`ifdef FRAME_TIMEOUT_EN
                wd    <= '0;
`endif
              end else begin
                cnt <= cnt + SIZE'(1);
              end
            end
          end
          // An arriving strobe takes precedence over an expiring watchdog.
          S_WAIT_FFT: begin
            if (finish_fft_i) begin
              state       <= S_KICK_OUT;
              out_start_o <= 1'b1;
            end
`ifdef FRAME_TIMEOUT_EN
            else if (wd_max) begin
              state         <= S_ERROR;
              err_timeout_o <= 1'b1;
            end else begin
              wd <= wd + TIMEOUT_W'(1);
            end
`endif
          end
          S_KICK_OUT: begin
            state <= S_WAIT_OUT;
`ifdef FRAME_TIMEOUT_EN
            wd    <= '0;
`endif
          end
          S_WAIT_OUT: begin
            if (out_done_i) begin
              state       <= S_DONE;
              done_o      <= 1'b1;
              frame_cnt_o <= frame_cnt_o + FRAMES_W'(1);
            end
`ifdef FRAME_TIMEOUT_EN
            else if (wd_max) begin
              state         <= S_ERROR;
              err_timeout_o <= 1'b1;
            end else begin
              wd <= wd + TIMEOUT_W'(1);
            end
`endif
          end
          S_DONE: begin
            if (continuous_i) begin
              state <= S_COLLECT;
              cnt   <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
          S_ERROR: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
